hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, EX-stage occupancy in cycles of a multi-cycle op (legal 2..16).
REQ-002 SHALL have port Clk  input  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port ID_UsesRt  input  1  ID instruction reads Rt.
REQ-006 SHALL have ports ID_Branch, ID_BranchTaken, ID_Jump  input  1 each  ID branch present, branch resolved taken, jump/jr in ID.
REQ-007 SHALL have ports EX_WriteReg  input  5, EX_RegWrite  input  1, EX_MemRead  input  2  destination, write enable and load type of the EX instruction.
REQ-008 SHALL have ports MEM_WriteReg  input  5, MEM_MemRead  input  2  destination and load type of the MEM instruction.
REQ-009 SHALL have port EX_MultiCycle  input  1  the EX instruction is a multi-cycle op.
REQ-010 SHALL have port Stall  output  1  drives stall select of the ID/EX control bubble mux.
REQ-011 SHALL have ports PCWrite, IFIDWrite  output  1 each  enable of PC and IF/ID registers.
REQ-012 SHALL have port IFIDFlush  output  1  clear IF/ID to NOP on next edge.
REQ-013 SHALL have port ExHold  output  1  freeze ID/EX register, zero EX/MEM controls.
REQ-014 SHALL have port StallCount  output  16  performance counter of stalled cycles.

Function
REQ-015 Register 0 SHALL never create a hazard.
REQ-016 LoadUse SHALL be true when EX_MemRead!=0 and EX_WriteReg matches ID_Rs, or matches ID_Rt with ID_UsesRt=1.
REQ-017 BrHaz SHALL be true when ID_Branch=1 and (EX_RegWrite=1 with EX_WriteReg matching ID_Rs/ID_Rt, or MEM_MemRead!=0 with MEM_WriteReg matching ID_Rs/ID_Rt).
REQ-018 FSM states SHALL be RUN and BUSY; 4-bit down-counter Cnt.
REQ-019 RUN, EX_MultiCycle=1: ExHold=1, Stall=1, PCWrite=IFIDWrite=0, IFIDFlush=0; load Cnt=MULT_CYCLES-2; next BUSY.
REQ-020 BUSY, Cnt>0: outputs as REQ-019; Cnt decrements; EX_MultiCycle ignored.
REQ-021 BUSY, Cnt=0: ExHold=0, normal RUN output rules apply, EX_MultiCycle ignored; next RUN.
REQ-022 Total ExHold cycles per multi-cycle op SHALL equal MULT_CYCLES-1.
REQ-023 RUN (or BUSY Cnt=0), LoadUse|BrHaz: Stall=1, PCWrite=IFIDWrite=0, IFIDFlush=0, combinational same cycle.
REQ-024 No hazard, ID_Jump|ID_BranchTaken: IFIDFlush=1 one cycle, PCWrite=IFIDWrite=1, Stall=0.
REQ-025 Priority SHALL be ExHold > LoadUse/BrHaz stall > flush; flush is suppressed while stalled.
REQ-026 Otherwise Stall=0, PCWrite=IFIDWrite=1, IFIDFlush=0, ExHold=0.
REQ-027 StallCount SHALL increment on every edge where Stall=1, wrapping 16'hFFFF->0.

Reset
REQ-028 Rst_n=0 SHALL immediately force state RUN, Cnt=0, StallCount=0, Stall=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0, ExHold=0, regardless of inputs.
REQ-029 Reset asserted mid-BUSY SHALL abort the hold; first cycle after release evaluates as RUN.

Structure
REQ-030 State encoding, bubble ALUOp constant 5'b10000 and MULT_CYCLES default SHALL live in shared package pipeline_defs.
REQ-031 Register-compare logic (REQ-015..017) SHALL be one combinational sub-module hazard_detect; FSM, counters, output priority in hazard_ctrl.

Verification
REQ-032 EX lw $t0 (EX_MemRead=2'b11, EX_WriteReg=8), ID_Rs=8 -> Stall=1, PCWrite=0, IFIDWrite=0 that cycle; StallCount +1.
REQ-033 EX_WriteReg=0 with EX_MemRead!=0, ID_Rs=0 -> no stall.
REQ-034 ID_Branch=1, ID_Rt=9, ID_UsesRt=1, EX_RegWrite=1, EX_WriteReg=9, ID_BranchTaken=1 -> Stall=1, IFIDFlush=0; next cycle hazard gone -> IFIDFlush=1.
REQ-035 MULT_CYCLES=4, EX_MultiCycle=1 held 4 cycles -> ExHold=1 exactly 3 cycles, released 4th; StallCount +3.
REQ-036 Rst_n low during 2nd ExHold cycle -> all outputs to reset values asynchronously; after release EX_MultiCycle=1 restarts a full 3-cycle hold.
REQ-037 Preload StallCount 16'hFFFF via 65535 stalls, one more stall -> 16'h0000.

Source files
------------

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: hazard FSM states, bubble ALUOp, multi-cycle default.
package pipeline_defs;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } hz_state_e;

    // ALUOp value carried by an ID/EX control bubble
    localparam logic [4:0] BUBBLE_ALUOP = 5'b10000;

    // Default EX-stage occupancy of a multi-cycle op (legal range 2..16)
    localparam int unsigned MULT_CYCLES_DEF = 4;

    // Width of the multi-cycle hold down-counter
    localparam int unsigned HOLD_CNT_W = 4;

endpackage

// File: rtl/hazard_detect.sv
// Register-compare hazard detection: load-use and branch-operand hazards.
// Register 0 is hard-wired zero and never produces a hazard.
module hazard_detect
    import pipeline_defs::*;
(
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_Branch,
    input  logic [4:0] EX_WriteReg,
    input  logic       EX_RegWrite,
    input  logic [1:0] EX_MemRead,
    input  logic [4:0] MEM_WriteReg,
    input  logic [1:0] MEM_MemRead,
    output logic       LoadUse,
    output logic       BrHaz
);

    logic w_ex_rs_hit;
    logic w_ex_rt_hit;
    logic w_mem_rs_hit;
    logic w_mem_rt_hit;

    // Destination/source matches, excluding register 0
    always_comb begin
        w_ex_rs_hit  = (EX_WriteReg  != '0) && (EX_WriteReg  == ID_Rs);
        w_ex_rt_hit  = (EX_WriteReg  != '0) && (EX_WriteReg  == ID_Rt);
        w_mem_rs_hit = (MEM_WriteReg != '0) && (MEM_WriteReg == ID_Rs);
        w_mem_rt_hit = (MEM_WriteReg != '0) && (MEM_WriteReg == ID_Rt);
    end

    // Load in EX feeding ID, and branch operands still in flight in EX/MEM
    always_comb begin
        LoadUse = (EX_MemRead != '0) && (w_ex_rs_hit || (ID_UsesRt && w_ex_rt_hit));
        BrHaz   = ID_Branch &&
                  ((EX_RegWrite && (w_ex_rs_hit || w_ex_rt_hit)) ||
                   ((MEM_MemRead != '0) && (w_mem_rs_hit || w_mem_rt_hit)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle EX hold FSM, stall/flush priority,
// and a free-running stalled-cycle performance counter.
module hazard_ctrl
    import pipeline_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF
)
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        ID_BranchTaken,
    input  logic        ID_Jump,
    input  logic [4:0]  EX_WriteReg,
    input  logic        EX_RegWrite,
    input  logic [1:0]  EX_MemRead,
    input  logic [4:0]  MEM_WriteReg,
    input  logic [1:0]  MEM_MemRead,
    input  logic        EX_MultiCycle,
    output logic        Stall,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        ExHold,
    output logic [15:0] StallCount
);

    localparam logic [HOLD_CNT_W-1:0] CNT_LOAD = HOLD_CNT_W'(MULT_CYCLES - 2);

    hz_state_e             r_state;
    hz_state_e             w_state_nxt;
    logic [HOLD_CNT_W-1:0] r_cnt;
    logic [HOLD_CNT_W-1:0] w_cnt_nxt;
    logic [15:0]           r_stall_cnt;
    logic                  w_load_use;
    logic                  w_br_haz;
    logic                  w_hold;

    hazard_detect u_detect (
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .ID_Branch    (ID_Branch),
        .EX_WriteReg  (EX_WriteReg),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .MEM_WriteReg (MEM_WriteReg),
        .MEM_MemRead  (MEM_MemRead),
        .LoadUse      (w_load_use),
        .BrHaz        (w_br_haz)
    );

    // EX hold: first cycle of a multi-cycle op in RUN, then BUSY until Cnt hits 0
    always_comb begin
        w_hold = ((r_state == RUN) && EX_MultiCycle) ||
                 ((r_state == BUSY) && (r_cnt != '0));
    end

    // State, hold counter and stall counter registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (Stall) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Next state: RUN->BUSY on a multi-cycle op; BUSY counts down, then returns to RUN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            RUN: begin
                if (EX_MultiCycle) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: reset override, then hold > data-hazard stall > control flush
    always_comb begin
        Stall     = 1'b0;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        ExHold    = 1'b0;
        if (Rst_n) begin
            if (w_hold) begin
                ExHold    = 1'b1;
                Stall     = 1'b1;
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
            end else if (w_load_use || w_br_haz) begin
                Stall     = 1'b1;
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
            end else if (ID_Jump || ID_BranchTaken) begin
                IFIDFlush = 1'b1;
            end
        end
    end

    // Expose the performance counter
    always_comb begin
        StallCount = r_stall_cnt;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a phase-based behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned M = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
    logic        ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
    logic        EX_RegWrite, EX_MultiCycle;
    logic [1:0]  EX_MemRead, MEM_MemRead;
    logic        Stall, PCWrite, IFIDWrite, IFIDFlush, ExHold;
    logic [15:0] StallCount;

    hazard_ctrl #(.MULT_CYCLES(M)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Branch      (ID_Branch),
        .ID_BranchTaken (ID_BranchTaken),
        .ID_Jump        (ID_Jump),
        .EX_WriteReg    (EX_WriteReg),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .MEM_WriteReg   (MEM_WriteReg),
        .MEM_MemRead    (MEM_MemRead),
        .EX_MultiCycle  (EX_MultiCycle),
        .Stall          (Stall),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFIDFlush      (IFIDFlush),
        .ExHold         (ExHold),
        .StallCount     (StallCount)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_phase is the 1-based cycle index within the current multi-cycle op
    // (0 = none). Cycles 1..M-1 hold, cycle M releases and ignores EX_MultiCycle.
    int   m_phase;
    int   m_cur;
    int   m_stall_cnt;
    logic e_stall, e_pcw, e_ifw, e_flush, e_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_stall_cnt = 0;
    endtask

    task automatic model_eval();
        bit lu, bh;
        e_stall = 1'b0; e_pcw = 1'b1; e_ifw = 1'b1; e_flush = 1'b0; e_hold = 1'b0;
        m_cur = 0;
        if (Rst_n) begin
            lu = (EX_MemRead != 0) && (EX_WriteReg != 0) &&
                 ((EX_WriteReg == ID_Rs) || (ID_UsesRt && EX_WriteReg == ID_Rt));
            bh = ID_Branch &&
                 ((EX_RegWrite && EX_WriteReg != 0 &&
                   (EX_WriteReg == ID_Rs || EX_WriteReg == ID_Rt)) ||
                  (MEM_MemRead != 0 && MEM_WriteReg != 0 &&
                   (MEM_WriteReg == ID_Rs || MEM_WriteReg == ID_Rt)));
            m_cur = (m_phase != 0) ? m_phase : (EX_MultiCycle ? 1 : 0);
            if (m_cur >= 1 && m_cur <= M - 1) begin
                e_hold = 1'b1; e_stall = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0;
            end else if (lu || bh) begin
                e_stall = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0;
            end else if (ID_Jump || ID_BranchTaken) begin
                e_flush = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        if (!Rst_n) begin
            model_reset();
        end else begin
            if (e_stall) m_stall_cnt = (m_stall_cnt + 1) % 65536;
            m_phase = (m_cur == 0 || m_cur == M) ? 0 : m_cur + 1;
        end
    endtask

    // Compare every output against the model, away from the clock edge
    task automatic settle_cmp();
        #1;
        if (!Rst_n) model_reset();
        model_eval();
        chk("cycle", {11'd0, Stall, PCWrite, IFIDWrite, IFIDFlush, ExHold, StallCount},
                     {11'd0, e_stall, e_pcw, e_ifw, e_flush, e_hold, 16'(m_stall_cnt)});
    endtask

    task automatic advance();
        model_eval();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
        ID_BranchTaken = 1'b0; ID_Jump = 1'b0; EX_WriteReg = '0; EX_RegWrite = 1'b0;
        EX_MemRead = '0; MEM_WriteReg = '0; MEM_MemRead = '0; EX_MultiCycle = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom % 4)
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom % 32);
        endcase
    endfunction

    task automatic rand_inputs();
        Rst_n          = ($urandom % 200) != 0;
        ID_Rs          = pick_reg();
        ID_Rt          = pick_reg();
        EX_WriteReg    = pick_reg();
        MEM_WriteReg   = pick_reg();
        ID_UsesRt      = 1'($urandom);
        ID_Branch      = ($urandom % 3) == 0;
        ID_BranchTaken = ID_Branch && 1'($urandom);
        ID_Jump        = ($urandom % 6) == 0;
        EX_RegWrite    = 1'($urandom);
        EX_MemRead     = (($urandom % 3) == 0) ? 2'($urandom) : 2'b00;
        MEM_MemRead    = (($urandom % 3) == 0) ? 2'($urandom) : 2'b00;
        EX_MultiCycle  = ($urandom % 10) == 0;
    endtask

    initial begin
        int   holds;
        logic last_hold;

        // Reset with hazard-provoking inputs: outputs must still be reset values
        Rst_n = 1'b0;
        idle_inputs();
        EX_MultiCycle = 1'b1; EX_MemRead = 2'b11; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        ID_Jump = 1'b1;
        model_reset();
        #2;
        chk("rst_outs", {27'd0, Stall, PCWrite, IFIDWrite, IFIDFlush, ExHold}, 32'b01100);
        chk("rst_cnt", {16'd0, StallCount}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle_inputs();
        settle_cmp();
        advance();

        // Load-use on Rs
        EX_MemRead = 2'b11; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        settle_cmp();
        chk("lu_stall", {29'd0, Stall, PCWrite, IFIDWrite}, 32'b100);
        advance();
        chk("lu_cnt", {16'd0, StallCount}, 32'd1);

        // Register 0 never hazards
        idle_inputs();
        EX_MemRead = 2'b01; ID_UsesRt = 1'b1;
        settle_cmp();
        chk("r0_nostall", {31'd0, Stall}, 32'd0);
        advance();

        // Branch hazard suppresses flush, then flush once hazard clears
        idle_inputs();
        ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_Rs = 5'd3; ID_Rt = 5'd9;
        ID_UsesRt = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
        settle_cmp();
        chk("br_stall", {30'd0, Stall, IFIDFlush}, 32'b10);
        advance();
        EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        settle_cmp();
        chk("br_flush", {29'd0, Stall, IFIDFlush, PCWrite}, 32'b011);
        advance();

        // Multi-cycle op held for M cycles
        idle_inputs();
        EX_MultiCycle = 1'b1;
        holds = 0; last_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle_cmp();
            holds += int'(ExHold);
            last_hold = ExHold;
            advance();
        end
        chk("mc_holds", holds, 32'd3);
        chk("mc_release4", {31'd0, last_hold}, 32'd0);
        chk("mc_cnt", {16'd0, StallCount}, 32'd5);
        EX_MultiCycle = 1'b0;
        settle_cmp();
        advance();

        // Reset during the second hold cycle, then a full hold afterwards
        EX_MultiCycle = 1'b1;
        settle_cmp();
        advance();
        settle_cmp();
        chk("mc_hold2", {31'd0, ExHold}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {27'd0, Stall, PCWrite, IFIDWrite, IFIDFlush, ExHold}, 32'b01100);
        chk("rst_mid_cnt", {16'd0, StallCount}, 32'd0);
        model_reset();
        @(posedge Clk);
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        holds = 0;
        for (int i = 0; i < 4; i++) begin
            settle_cmp();
            holds += int'(ExHold);
            advance();
        end
        chk("mc_rst_holds", holds, 32'd3);
        chk("mc_rst_cnt", {16'd0, StallCount}, 32'd3);
        EX_MultiCycle = 1'b0;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            settle_cmp();
            advance();
        end

        // Counter wrap: 65535 stalls from reset, then one more
        Rst_n = 1'b0;
        idle_inputs();
        settle_cmp();
        advance();
        Rst_n = 1'b1;
        EX_MemRead = 2'b10; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        for (int i = 0; i < 65535; i++) begin
            advance();
        end
        chk("wrap_pre", {16'd0, StallCount}, 32'h0000_FFFF);
        settle_cmp();
        advance();
        chk("wrap", {16'd0, StallCount}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
